serial_adder_ctrl: RTL and testbench

//  Bit-serial adder sequencer. It accepts two WIDTH-bit operands, then adds

---
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared NAND-based full-adder cell,
// LSB first, with carry flop, bit counter and operand/result shifters.
module serial_adder_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  logic n0, n1, n2;

  assign n0  = ~(x_i & y_i);
  assign n1  = ~(x_i & n0);
  assign n2  = ~(y_i & n0);
  assign s_o = ~(n1 & n2);
  assign c_o = ~n0;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s1, c1, s2, c2;
  logic             fa_s, fa_c;
  logic [WIDTH:0]   shift;

  serial_adder_ha u_ha0 (
    .x_i (a_q[0]),
    .y_i (b_q[0]),
    .s_o (s1),
    .c_o (c1)
  );

  serial_adder_ha u_ha1 (
    .x_i (s1),
    .y_i (carry_q),
    .s_o (s2),
    .c_o (c2)
  );

  assign fa_s  = s2;
  assign fa_c  = c1 | c2;
  // New bit enters at the MSB; the slice also covers WIDTH=1.
  assign shift = {fa_s, res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        res_d   = shift[WIDTH:1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = shift[WIDTH:1];
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
// Driver pushes expected results; monitor pops them on done.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, cin, ready, busy, done, cout_out;
  logic [7:0] a_in, b_in, sum_out;
  logic       start1, a1, b1, c1, ready1, busy1, done1, sum1, cout1;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .a_in     (a1),
    .b_in     (b1),
    .cin      (c1),
    .ready    (ready1),
    .busy     (busy1),
    .done     (done1),
    .sum_out  (sum1),
    .cout_out (cout1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  int         acc_q[$];
  logic [1:0] exp1_q[$];
  int         acc1_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: one-hot status every cycle, result and latency on done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot8", $countones({ready, busy, done}), 1);
      chk("onehot1", $countones({ready1, busy1, done1}), 1);
      if (done) begin
        if (exp_q.size() == 0) flag("unexpected_done8");
        else begin
          chk("sum8", {cout_out, sum_out}, exp_q.pop_front());
          chk("lat8", cyc - acc_q.pop_front(), 8);
        end
      end
      if (done1) begin
        if (exp1_q.size() == 0) flag("unexpected_done1");
        else begin
          chk("sum1", {cout1, sum1}, exp1_q.pop_front());
          chk("lat1", cyc - acc1_q.pop_front(), 1);
        end
      end
    end
  end

  // Called at a negedge; operands are scrambled after the accept edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input bit push);
    int g = 0;
    while (!ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ready) begin
      flag("ready_timeout8");
      return;
    end
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    if (push) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + 9'(c));
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    cin   = ~c;
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int g = 0;
    while (!ready1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!ready1) begin
      flag("ready_timeout1");
      return;
    end
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    c1     = c;
    exp1_q.push_back(2'(a) + 2'(b) + 2'(c));
    acc1_q.push_back(cyc + 1);
    @(negedge clk);
    start1 = 1'b0;
    a1     = ~a;
    b1     = ~b;
    c1     = ~c;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      flag("drain_timeout");
      exp_q.delete();
      acc_q.delete();
      exp1_q.delete();
      acc1_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nacc, prev, guard;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    c1     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", {cout_out, sum_out}, 0);
    chk("rst_w1", {ready1, busy1, done1, cout1, sum1}, 5'b10000);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h3C, 8'h0F, 1'b0, 1'b1);
    drain();

    op8(8'hFF, 8'h01, 1'b0, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 1'b1);
    drain();

    op8(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ready_in_run", ready, 0);
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    @(negedge clk);
    chk("ready_in_run2", ready, 0);
    start = 1'b0;
    drain();

    op8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", {cout_out, sum_out}, 0);
    op8(8'h5A, 8'h66, 1'b1, 1'b1);
    drain();

    nacc  = 0;
    prev  = -1;
    guard = 0;
    while (nacc < 100 && guard < 5000) begin
      @(negedge clk);
      guard++;
      start = 1'b1;
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
      cin   = 1'($urandom);
      if (ready) begin
        exp_q.push_back({1'b0, a_in} + {1'b0, b_in} + 9'(cin));
        acc_q.push_back(cyc + 1);
        if (prev >= 0) chk("accept_gap", cyc + 1 - prev, 10);
        prev = cyc + 1;
        nacc++;
      end
    end
    if (nacc < 100) flag("stream_timeout");
    @(negedge clk);
    start = 1'b0;
    drain();

    op1(1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b0, 1'b1);
    op1(1'b1, 1'b0, 1'b1);
    op1(1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
